// File: rtl/pps_in_capture.sv
// rtl/pps_in_capture.sv - 1PPS input capture: synchroniser, compensated timestamp, period/width, lock and missing-pulse monitor
module pps_in_capture #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [31:0] PERIOD_TOL_NS = 32'd1000,
    parameter int unsigned LOCK_CNT      = 4
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst_n,
    input  logic        enable_i,
    input  logic [31:0] tick_inc_i,
    input  logic [79:0] rtc_std_i,
    input  logic [15:0] rtc_fns_i,
    input  logic        pps_i,
    output logic [79:0] ts_std_o,
    output logic [15:0] ts_fns_o,
    output logic [31:0] period_ns_o,
    output logic [31:0] width_ns_o,
    output logic        ts_valid_o,
    input  logic        ts_ack_i,
    output logic        overrun_o,
    output logic        missing_o,
    output logic        locked_o,
    output logic        irq_o
);

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
    localparam logic [31:0] PERIOD_LO  = NS_PER_SEC - PERIOD_TOL_NS;
    localparam logic [31:0] PERIOD_HI  = NS_PER_SEC + PERIOD_TOL_NS;
    localparam logic [47:0] SEC_FX     = 48'd65_536_000_000_000;
    localparam logic [24:0] LAT_MULT   = 25'(SYNC_STAGES + 1);
    localparam logic [3:0]  LOCK_TGT   = 4'(LOCK_CNT);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_t;

    // Interval between two sec/ns instants; anything beyond 2 s saturates.
    function automatic logic [31:0] span_ns(
        input logic [47:0] sec_a,
        input logic [31:0] ns_a,
        input logic [47:0] sec_b,
        input logic [31:0] ns_b
    );
        logic [47:0] dsec;
        dsec    = sec_a - sec_b;
        span_ns = 32'hFFFF_FFFF;
        if (dsec == 48'd0)
            span_ns = ns_a - ns_b;
        else if (dsec == 48'd1)
            span_ns = NS_PER_SEC + ns_a - ns_b;
        else if (dsec == 48'd2)
            span_ns = 32'd2_000_000_000 + ns_a - ns_b;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   sync_last;
    logic                   rise;
    logic                   fall;

    logic [21:0] tick_fx;
    logic [24:0] lat_fx;
    logic [47:0] now_fx;
    logic [47:0] now_sec;
    logic [47:0] comp_fx;
    logic [47:0] comp_sec;
    logic [31:0] comp_ns;
    logic        borrow;
    logic        unused_tick;

    logic [47:0] ref_sec_q;
    logic [31:0] ref_ns_q;
    logic [31:0] rise_ns_q;
    logic        have_ref_q;
    logic        have_rise_q;

    logic [31:0] span_now;
    logic [31:0] width_new;
    logic        period_good;
    logic        period_evt;
    logic        miss_fire;

    lock_state_t state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rise      = sync_last & ~sync_d_q;
    assign fall      = ~sync_last & sync_d_q;

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else if (!enable_i) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pps_i};
            sync_d_q <= sync_last;
        end
    end

    // The edge happened (SYNC_STAGES+1) ticks before detection; back the RTC off by that much.
    assign tick_fx     = tick_inc_i[31:10];
    assign unused_tick = ^tick_inc_i[9:0];
    assign lat_fx      = {3'b000, tick_fx} * LAT_MULT;
    assign now_fx      = {rtc_std_i[31:0], rtc_fns_i};
    assign now_sec     = rtc_std_i[79:32];
    assign borrow      = now_fx < {23'd0, lat_fx};
    assign comp_fx     = borrow ? (now_fx + SEC_FX - {23'd0, lat_fx})
                                : (now_fx - {23'd0, lat_fx});
    assign comp_sec    = borrow ? (now_sec - 48'd1) : now_sec;
    assign comp_ns     = comp_fx[47:16];

    // Elapsed-since-reference and capture period share one comparator: both use compensated now.
    assign span_now    = span_ns(comp_sec, comp_ns, ref_sec_q, ref_ns_q);
    assign period_good = (span_now >= PERIOD_LO) && (span_now <= PERIOD_HI);
    assign period_evt  = rise & have_ref_q;
    assign miss_fire   = have_ref_q & ~missing_o & ~rise & (span_now > PERIOD_HI);
    assign width_new   = (comp_ns >= rise_ns_q) ? (comp_ns - rise_ns_q)
                                                : (comp_ns + NS_PER_SEC - rise_ns_q);

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            ts_std_o    <= '0;
            ts_fns_o    <= '0;
            period_ns_o <= '0;
            width_ns_o  <= '0;
            ts_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
            missing_o   <= 1'b0;
            irq_o       <= 1'b0;
            ref_sec_q   <= '0;
            ref_ns_q    <= '0;
            rise_ns_q   <= '0;
            have_ref_q  <= 1'b0;
            have_rise_q <= 1'b0;
        end else if (!enable_i) begin
            ts_std_o    <= '0;
            ts_fns_o    <= '0;
            period_ns_o <= '0;
            width_ns_o  <= '0;
            ts_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
            missing_o   <= 1'b0;
            irq_o       <= 1'b0;
            ref_sec_q   <= '0;
            ref_ns_q    <= '0;
            rise_ns_q   <= '0;
            have_ref_q  <= 1'b0;
            have_rise_q <= 1'b0;
        end else begin
            irq_o <= rise | miss_fire;
            if (rise) begin
                ts_std_o    <= {comp_sec, comp_ns};
                ts_fns_o    <= comp_fx[15:0];
                ts_valid_o  <= 1'b1;
                // A same-cycle ack consumes the old value, so the new one is not an overrun.
                overrun_o   <= (overrun_o | ts_valid_o) & ~ts_ack_i;
                missing_o   <= 1'b0;
                ref_sec_q   <= comp_sec;
                ref_ns_q    <= comp_ns;
                rise_ns_q   <= comp_ns;
                have_ref_q  <= 1'b1;
                have_rise_q <= 1'b1;
                if (have_ref_q)
                    period_ns_o <= span_now;
            end else begin
                if (ts_ack_i) begin
                    ts_valid_o <= 1'b0;
                    overrun_o  <= 1'b0;
                end
                if (miss_fire)
                    missing_o <= 1'b1;
            end
            if (fall && have_rise_q)
                width_ns_o <= width_new;
        end
    end

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            state_q    <= ST_UNLOCKED;
            good_cnt_q <= '0;
        end else if (!enable_i) begin
            state_q    <= ST_UNLOCKED;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (miss_fire) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
        end else if (period_evt) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (period_good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_TGT)
                            state_d = ST_LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!period_good) begin
                        state_d    = ST_UNLOCKED;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: doc/pps_in_capture.md
Name: pps_in_capture

Overview:
- Receiver-side monitor for an external 1PPS input in the RTC clock domain.
- Synchronises `pps_i`, then timestamps the rising edge against the RTC. Timestamps are compensated for synchroniser latency.
- Measures pulse width and the edge-to-edge period, and checks the period against 1 s ± tolerance.
- Tracks lock/missing-pulse status and hands each timestamp to software through a valid/ack holding register. Sits beside the PPS output generator and feeds the register file/interrupt controller.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on `pps_i` (legal 2..4).
- PERIOD_TOL_NS, 32'd1000: allowed |period − 1e9| in ns.
- LOCK_CNT, 4: consecutive good periods needed to declare lock (1..15).

Ports:
- `rtc_clk`  in  1  RTC clock.
- `rtc_rst_n`  in  1  asynchronous reset, active low.
- `enable_i`  in  1  block enable; 0 holds all state at reset values.
- `tick_inc_i`  in  32  per-cycle RTC increment, 6.26 unsigned ns.
- `rtc_std_i`  in  80  current time: [79:32] seconds, [31:0] ns (< 1e9).
- `rtc_fns_i`  in  16  current fractional ns.
- `pps_i`  in  1  asynchronous PPS input.
- `ts_std_o`  out  80  compensated rising-edge timestamp (sec+ns).
- `ts_fns_o`  out  16  compensated timestamp fractional ns.
- `period_ns_o`  out  32  last edge-to-edge interval, ns.
- `width_ns_o`  out  32  last high-pulse width, ns.
- `ts_valid_o`  out  1  holding register contains an unread timestamp.
- `ts_ack_i`  in  1  software read acknowledge, single-cycle pulse.
- `overrun_o`  out  1  sticky: an edge overwrote an unacked timestamp.
- `missing_o`  out  1  sticky: expected pulse not seen.
- `locked_o`  out  1  lock status.
- `irq_o`  out  1  one-cycle pulse on each capture or on missing detect.

Behaviour:
- Reset / `enable_i`=0: all outputs 0, state UNLOCKED, synchroniser cleared, `have_ref`=0.
- Edge detect: rise = sync_last & ~d; fall = ~sync_last & d.
- Latency compensation:
  - C = (SYNC_STAGES+1) × tick; ns part = `tick_inc_i`[31:26], fns part = `tick_inc_i`[25:10].
  - Captured {ns,fns} = current {ns,fns} − C.
  - On borrow below 0: ns += 1e9 and seconds −= 1.
  - Compensated timestamp is registered 1 cycle after rise, i.e. `ts_valid_o` rises 1 cycle after rise is detected.
- Holding register:
  - On capture: `ts_valid_o`=1.
  - If `ts_valid_o` was already 1 and no ack arrives the same cycle: overwrite with the new value and set `overrun_o`.
  - `ts_ack_i` clears `ts_valid_o` and `overrun_o`. Capture in the same cycle as ack wins: valid stays 1, overrun not set.
- Period measurement, on each capture with `have_ref`=1:
  - dsec = sec_new − sec_ref.
  - dsec ∈ {0,1,2}: delta = dsec×1e9 + ns_new − ns_ref (32-bit unsigned).
  - Otherwise delta = 32'hFFFF_FFFF.
  - `period_ns_o` = delta. Good iff |delta − 1e9| ≤ PERIOD_TOL_NS.
  - The reference is then updated to the new timestamp, and `have_ref`=1 after the first capture.
- Width measurement: on fall, `width_ns_o` = (ns_now − ns_rise) mod 1e9, using the compensated rise ns. A fall with no prior rise is ignored.
- Missing detect:
  - While `have_ref`=1, elapsed = (current time − reference) is computed with the same rule as delta.
  - When elapsed > 1e9 + PERIOD_TOL_NS and `missing_o`=0: set `missing_o`, pulse `irq_o`, go to UNLOCKED, clear good count.
  - Detect fires once per gap; `missing_o` clears on the next capture.
- Lock FSM:
  - UNLOCKED: good period → count+1; on count == LOCK_CNT → LOCKED (`locked_o`=1). Bad period → count=0.
  - LOCKED: bad period or missing → UNLOCKED, count=0.
  - The first capture after reset/enable is not a period and does not count.
- `irq_o`: pulses in the same cycle `ts_valid_o` is set, and on missing detect. If both events occur in the same cycle, there is a single pulse.
- Glitch: a high pulse shorter than SYNC_STAGES cycles may be missed; no filtering beyond the synchroniser.

Test Plan:
1. Capture and compensation: `tick_inc_i`=32'h1999999A (6.4 ns), SYNC_STAGES=2, edge where RTC reads 5 s + 500 ns at detection → `ts_std_o` = 5 s / 480 ns (C = 19.2 ns); `ts_valid_o`=1 and `irq_o` pulse one cycle later.
2. Period and lock: 5 PPS edges exactly 1 s apart → `period_ns_o`=1e9 each; `locked_o`=1 after the 5th edge (4 good periods).
3. Tolerance boundary: period 1e9+1000 → good; period 1e9+1001 → `locked_o` drops, count resets.
4. Missing pulse: locked, stop PPS → `missing_o`=1 and one `irq_o` when elapsed reaches 1e9+1001 ns; the next edge clears `missing_o` and reports a ~2e9 period (bad).
5. Handshake: two edges with no ack → `overrun_o`=1 and the second timestamp is held. Ack → `ts_valid_o`=0, `overrun_o`=0. Ack coincident with an edge → valid stays 1, no overrun.
6. Borrow and width: edge detected at 7 s + 10 ns → `ts_std_o` = 6 s / 999_999_990.8 ns. With a 100 ms high pulse → `width_ns_o`=100_000_000 ±1 tick. Async reset mid-pulse → all outputs 0.
